hilo_commit: RTL and testbench
==============================

# hilo_commit

Holding and commit stage for the architectural HI/LO register pair, directly downstream of the mult/div ALU. Captures each 64-bit multiply/divide result when the ALU reports ready, holds it in a one-entry pending buffer until the owning instruction commits, and drops it on an exception flush. It also applies MTHI/MTLO writes and serves MFHI/MFLO reads, with optional forwarding from the pending buffer.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mult_div_ready  in  1  one-cycle pulse: result valid this cycle
- res_sel_div  in  1  sampled with mult_div_ready; 1 = div_result, 0 = mult_result
- div_result  in  64  {remainder[63:32], quotient[31:0]}
- mult_result  in  64  {product_hi[63:32], product_lo[31:0]}
- commit_i  in  1  instruction owning the pending result retires this cycle
- flush_i  in  1  exception flush from M stage
- mthi_we  in  1  MTHI write strobe
- mtlo_we  in  1  MTLO write strobe
- mt_data  in  32  MTHI/MTLO data
- hi_o  out  32  HI value seen by MFHI
- lo_o  out  32  LO value seen by MFLO
- pending_o  out  1  pending buffer holds an uncommitted result
- hilo_stall_o  out  1  MFHI/MFLO must stall (forwarding disabled only)
- ovr_err_o  out  1  sticky: pending result overwritten before commit

## Operation
- State: hi_arch, lo_arch (32 each), pend_hi, pend_lo (32 each), a two-state FSM (IDLE, PEND), ovr_err.
- Sample: on mult_div_ready, {pend_hi, pend_lo} <= res_sel_div ? div_result : mult_result.
- IDLE -> PEND: mult_div_ready & ~flush_i.
- PEND -> IDLE: commit_i & ~flush_i & ~mult_div_ready; {hi_arch, lo_arch} <= pending.
- PEND -> PEND with commit_i & mult_div_ready & ~flush_i: commit the old pending to arch, load the new result.
- PEND -> PEND with mult_div_ready & ~commit_i & ~flush_i: overwrite pending and set ovr_err (sticky until reset).
- Any state with flush_i: -> IDLE. Pending is discarded. ready, commit and MT writes in that cycle are ignored. Arch is unchanged.
- mthi_we/mtlo_we (when ~flush_i): write hi_arch/lo_arch. If PEND, also overwrite pend_hi/pend_lo, so the younger MT wins at commit.
- In the same cycle, a commit of pending plus an MT write to the same half: the MT data wins in arch.
- Reads: hi_o = (PEND) ? pend_hi : hi_arch. lo_o is formed the same way. See Configuration.

## Timing
- Reset: hi_arch = lo_arch = pend_hi = pend_lo = 0, FSM in IDLE, all outputs 0. Reset takes effect immediately, including mid-PEND.
- mult_div_ready at edge N: pending_o = 1 and the forwarded hi_o/lo_o show the new value after edge N+1.
- commit_i at edge M: hi_arch/lo_arch update at M+1, and pending_o falls at M+1 unless a new ready arrives in the same cycle.
- MT write at edge K: hi_o/lo_o reflect it after K+1.
- All outputs are registered-state derived; there is no combinational path from inputs to outputs.
- hilo_stall_o equals the PEND state (forwarding disabled) or is 0 (enabled).

## Configuration
- HILO_FWD_EN defined:
  - hi_o/lo_o forward pending values while in PEND.
  - hilo_stall_o is tied to 0.
- HILO_FWD_EN undefined:
  - hi_o/lo_o always show hi_arch/lo_arch.
  - hilo_stall_o = 1 whenever in PEND, so the pipeline holds MFHI/MFLO until commit.

## Test plan
- Mult commit: ready, sel = 0, mult_result = 0x00000001_FFFFFFFE; commit 2 cycles later -> pending_o = 1 for 2 cycles; then hi_o = 0x1, lo_o = 0xFFFFFFFE with pending_o = 0.
- Div flush: ready, sel = 1, div_result = 0x00000003_00000007; flush_i next cycle -> pending_o = 0, and hi_o/lo_o keep their prior values (0/0 after reset).
- MT over pending: load pending 0xAAAA_AAAA/0xBBBB_BBBB, mthi 0x1234_5678, then commit -> hi_o = 0x12345678, lo_o = 0xBBBBBBBB.
- Back-to-back: commit and a new ready (0x5/0x6) in the same cycle -> arch = old pending, pending = 5/6, pending_o stays 1, ovr_err_o = 0. Two readies with no commit -> ovr_err_o = 1.
- Async reset mid-PEND: assert rst low between clock edges -> all outputs are 0 immediately.
- Forwarding: with HILO_FWD_EN, pending 0x9/0x8 gives hi_o = 0x9 before commit. Without it, hi_o = arch value and hilo_stall_o = 1 until commit.

Source files
------------

// File: rtl/hilo_commit.sv
// +----------------------------------------------------------------------------+
// | Module  : hilo_commit                                                      |
// | Desc    : HI/LO pending-result buffer and architectural commit stage.      |
// |           Define HILO_FWD_EN to forward pending values to MFHI/MFLO.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module hilo_commit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_div_ready,
  input  logic        res_sel_div,
  input  logic [63:0] div_result,
  input  logic [63:0] mult_result,
  input  logic        commit_i,
  input  logic        flush_i,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        pending_o,
  output logic        hilo_stall_o,
  output logic        ovr_err_o
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_PEND = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_hi_arch;
  logic [31:0] r_lo_arch;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_ovr_err;

  logic        w_pend;
  logic        w_ready;
  logic        w_commit;
  logic        w_mthi;
  logic        w_mtlo;
  logic [63:0] w_result;

  // A flush cancels every other request arriving in the same cycle.
  assign w_pend   = (r_state == c_PEND);
  assign w_ready  = mult_div_ready & ~flush_i;
  assign w_commit = commit_i & w_pend & ~flush_i;
  assign w_mthi   = mthi_we & ~flush_i;
  assign w_mtlo   = mtlo_we & ~flush_i;
  assign w_result = res_sel_div ? div_result : mult_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else if (flush_i) begin
      r_state <= c_IDLE;
    end else if (w_ready) begin
      r_state <= c_PEND;
    end else if (w_commit) begin
      r_state <= c_IDLE;
    end
  end

  // MT writes are younger than the committing result, so they take priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi_arch <= 32'd0;
      r_lo_arch <= 32'd0;
    end else begin
      if (w_mthi) begin
        r_hi_arch <= mt_data;
      end else if (w_commit) begin
        r_hi_arch <= r_pend_hi;
      end
      if (w_mtlo) begin
        r_lo_arch <= mt_data;
      end else if (w_commit) begin
        r_lo_arch <= r_pend_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else if (w_ready) begin
      r_pend_hi <= w_result[63:32];
      r_pend_lo <= w_result[31:0];
    end else if (w_pend && !flush_i) begin
      if (w_mthi) begin
        r_pend_hi <= mt_data;
      end
      if (w_mtlo) begin
        r_pend_lo <= mt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr_err <= 1'b0;
    end else if (w_pend && w_ready && !commit_i) begin
      r_ovr_err <= 1'b1;
    end
  end

  assign pending_o = w_pend;
  assign ovr_err_o = r_ovr_err;

`ifdef HILO_FWD_EN
  assign hi_o         = w_pend ? r_pend_hi : r_hi_arch;
  assign lo_o         = w_pend ? r_pend_lo : r_lo_arch;
  assign hilo_stall_o = 1'b0;
`else
  assign hi_o         = r_hi_arch;
  assign lo_o         = r_lo_arch;
  assign hilo_stall_o = w_pend;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_commit.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_hilo_commit                                                   |
// | Desc    : Directed self-checking bench for hilo_commit.                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hilo_commit;

  logic        clk;
  logic        rst;
  logic        mult_div_ready;
  logic        res_sel_div;
  logic [63:0] div_result;
  logic [63:0] mult_result;
  logic        commit_i;
  logic        flush_i;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        pending_o;
  logic        hilo_stall_o;
  logic        ovr_err_o;

  int errors = 0;
  int checks = 0;

`ifdef HILO_FWD_EN
  localparam bit c_FWD = 1'b1;
`else
  localparam bit c_FWD = 1'b0;
`endif

  hilo_commit dut (
    .clk            (clk),
    .rst            (rst),
    .mult_div_ready (mult_div_ready),
    .res_sel_div    (res_sel_div),
    .div_result     (div_result),
    .mult_result    (mult_result),
    .commit_i       (commit_i),
    .flush_i        (flush_i),
    .mthi_we        (mthi_we),
    .mtlo_we        (mtlo_we),
    .mt_data        (mt_data),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .pending_o      (pending_o),
    .hilo_stall_o   (hilo_stall_o),
    .ovr_err_o      (ovr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stall expectation depends on build: pending state without forwarding, else 0.
  function automatic logic [31:0] stall_exp(input logic pend);
    return {31'd0, pend & ~c_FWD};
  endfunction

  initial begin
    rst = 1'b0; mult_div_ready = 1'b0; res_sel_div = 1'b0;
    div_result = 64'd0; mult_result = 64'd0; commit_i = 1'b0; flush_i = 1'b0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = 32'd0;
    #1;
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_pend", {31'd0, pending_o}, 32'd0);
    check("rst_stall", {31'd0, hilo_stall_o}, 32'd0);
    check("rst_ovr", {31'd0, ovr_err_o}, 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // Multiply result, committed two cycles after capture
    mult_div_ready = 1'b1; res_sel_div = 1'b0; mult_result = 64'h00000001_FFFFFFFE;
    div_result = 64'hDEADBEEF_DEADBEEF;
    step();
    mult_div_ready = 1'b0;
    check("mul_pend1", {31'd0, pending_o}, 32'd1);
    check("mul_stall", {31'd0, hilo_stall_o}, stall_exp(1'b1));
    check("mul_fwd_hi", hi_o, c_FWD ? 32'h1 : 32'h0);
    step();
    check("mul_pend2", {31'd0, pending_o}, 32'd1);
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("mul_cmt_pend", {31'd0, pending_o}, 32'd0);
    check("mul_cmt_hi", hi_o, 32'h00000001);
    check("mul_cmt_lo", lo_o, 32'hFFFFFFFE);
    check("mul_cmt_stall", {31'd0, hilo_stall_o}, 32'd0);

    // Divide result dropped by a flush
    mult_div_ready = 1'b1; res_sel_div = 1'b1; div_result = 64'h00000003_00000007;
    mult_result = 64'h55555555_55555555;
    step();
    mult_div_ready = 1'b0;
    check("div_pend", {31'd0, pending_o}, 32'd1);
    check("div_fwd_lo", lo_o, c_FWD ? 32'h7 : 32'hFFFFFFFE);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("div_fl_pend", {31'd0, pending_o}, 32'd0);
    check("div_fl_hi", hi_o, 32'h00000001);
    check("div_fl_lo", lo_o, 32'hFFFFFFFE);

    // MTHI while a result is pending overrides the pending HI half
    mult_div_ready = 1'b1; res_sel_div = 1'b0; mult_result = 64'hAAAAAAAA_BBBBBBBB;
    step();
    mult_div_ready = 1'b0;
    mthi_we = 1'b1; mt_data = 32'h12345678;
    step();
    mthi_we = 1'b0;
    check("mt_pend_hi", hi_o, 32'h12345678);
    check("mt_pend_lo", lo_o, c_FWD ? 32'hBBBBBBBB : 32'hFFFFFFFE);
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("mt_cmt_hi", hi_o, 32'h12345678);
    check("mt_cmt_lo", lo_o, 32'hBBBBBBBB);

    // Commit and MTLO in the same cycle: MT data lands in arch LO
    mult_div_ready = 1'b1; mult_result = 64'h11111111_22222222;
    step();
    mult_div_ready = 1'b0;
    commit_i = 1'b1; mtlo_we = 1'b1; mt_data = 32'hCAFEF00D;
    step();
    commit_i = 1'b0; mtlo_we = 1'b0;
    check("mtc_hi", hi_o, 32'h11111111);
    check("mtc_lo", lo_o, 32'hCAFEF00D);
    check("mtc_pend", {31'd0, pending_o}, 32'd0);

    // Back-to-back: commit plus new ready, then an overwrite
    mult_div_ready = 1'b1; mult_result = 64'hDEAD0001_DEAD0002;
    step();
    commit_i = 1'b1; mult_result = 64'h00000005_00000006;
    step();
    commit_i = 1'b0;
    check("b2b_pend", {31'd0, pending_o}, 32'd1);
    check("b2b_ovr", {31'd0, ovr_err_o}, 32'd0);
    check("b2b_hi", hi_o, c_FWD ? 32'h5 : 32'hDEAD0001);
    check("b2b_lo", lo_o, c_FWD ? 32'h6 : 32'hDEAD0002);
    mult_result = 64'h00000007_00000008;
    step();
    mult_div_ready = 1'b0;
    check("ovr_set", {31'd0, ovr_err_o}, 32'd1);
    check("ovr_pend", {31'd0, pending_o}, 32'd1);
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("ovr_cmt_hi", hi_o, 32'h7);
    check("ovr_cmt_lo", lo_o, 32'h8);
    check("ovr_sticky", {31'd0, ovr_err_o}, 32'd1);

    // MT write and commit during a flush are ignored
    mthi_we = 1'b1; mt_data = 32'hFFFF0000; commit_i = 1'b1; flush_i = 1'b1;
    step();
    mthi_we = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
    check("fl_mt_hi", hi_o, 32'h7);

    // Asynchronous reset between edges while pending
    mult_div_ready = 1'b1; mult_result = 64'h00000009_00000008;
    step();
    mult_div_ready = 1'b0;
    check("fwd_hi", hi_o, c_FWD ? 32'h9 : 32'h7);
    check("fwd_stall", {31'd0, hilo_stall_o}, stall_exp(1'b1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_hi", hi_o, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    check("arst_pend", {31'd0, pending_o}, 32'd0);
    check("arst_stall", {31'd0, hilo_stall_o}, 32'd0);
    check("arst_ovr", {31'd0, ovr_err_o}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_pend", {31'd0, pending_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
